// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register file geometry
// and the hard-wired zero register index.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One register file read port: storage mux, writeback
// bypass and scoreboard busy lookup.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic is_zero;
  logic hit;

  assign is_zero = (ZERO_REG != 0)
                && (addr == ADDR_W'(REG_ZERO));
  assign hit = wr_en && (wr_addr == addr);

  // select bypass or stored value; reset forces zero
  always_comb begin
    rd_data = rf[addr];
    rd_busy = busy[addr] && !hit;
    if (hit) rd_data = wr_data;
    if (is_zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
    if (reset) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file with write-to-read bypass and a
// per-register busy scoreboard with registered popcount.
module mips_regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok = wr_en && !((ZERO_REG != 0)
              && (wr_addr == ADDR_W'(REG_ZERO)));
  assign iss_ok = iss_en && !((ZERO_REG != 0)
               && (iss_addr == ADDR_W'(REG_ZERO)));

  // writeback into storage; zero register never written
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wr_addr] <= wr_data;
    end
  end

  // next busy vector: writeback clears, issue sets and wins
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[wr_addr] = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
  end

  // popcount of the next busy vector
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  // scoreboard and count registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .reset  (reset),
      .addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .rf     (rf),
      .busy   (busy),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(rd_data[p*DATA_W +: DATA_W]),
      .rd_busy(rd_busy[p])
    );
  end

endmodule
